// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: input conditioning, frame checking, E0/F0 prefix
// folding and a first-word fall-through event FIFO, all on CLOCK_50.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8,
    parameter int ERR_W          = 8
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             PS2_KBCLK,
    input  logic             PS2_KBDAT,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [9:0]       evt_data,
    output logic [15:0]      display,
    output logic [ERR_W-1:0] err_cnt,
    output logic             overflow
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [FCW-1:0] FILTER_LAST  = FCW'(FILTER_LEN - 1);
    localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } state_t;

    // Synchroniser chains
    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] datSync_q;
    logic                   clkS;
    logic                   datS;

    // Glitch filter
    logic           filtClk_q;
    logic           filtPrev_q;
    logic [FCW-1:0] filtCnt_q;
    logic           fe;

    // Frame FSM
    state_t        state_q, state_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parOk_q, parOk_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          frameGood_q, frameGood_d;
    logic          frameBad_q, frameBad_d;
    logic [7:0]    frameByte_q;

    // Decode
    logic             ext_q;
    logic             brk_q;
    logic [15:0]      display_q;
    logic [ERR_W-1:0] errCnt_q;
    logic             overflow_q;
    logic             push;
    logic [9:0]       pushData;

    // FIFO
    logic [9:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wrPtr_q;
    logic [AW:0] rdPtr_q;
    logic        fifoEmpty;
    logic        fifoFull;
    logic        pop;
    logic        wrEn;

    assign clkS = clkSync_q[SYNC_STAGES-1];
    assign datS = datSync_q[SYNC_STAGES-1];

    // Bring both raw PS/2 lines into CLOCK_50 through a shift chain idling high
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            clkSync_q <= '1;
            datSync_q <= '1;
        end else begin
            clkSync_q <= {clkSync_q[SYNC_STAGES-2:0], PS2_KBCLK};
            datSync_q <= {datSync_q[SYNC_STAGES-2:0], PS2_KBDAT};
        end
    end

    // Flip the filtered clock only after FILTER_LEN consecutive differing samples
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            filtClk_q  <= 1'b1;
            filtPrev_q <= 1'b1;
            filtCnt_q  <= '0;
        end else begin
            filtPrev_q <= filtClk_q;
            if (clkS == filtClk_q) begin
                filtCnt_q <= '0;
            end else if (filtCnt_q == FILTER_LAST) begin
                filtClk_q <= clkS;
                filtCnt_q <= '0;
            end else begin
                filtCnt_q <= filtCnt_q + 1'b1;
            end
        end
    end

    assign fe = filtPrev_q & ~filtClk_q;

    // Frame FSM state register and registered end-of-frame strobes
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parOk_q     <= 1'b0;
            timer_q     <= '0;
            frameGood_q <= 1'b0;
            frameBad_q  <= 1'b0;
            frameByte_q <= '0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parOk_q     <= parOk_d;
            timer_q     <= timer_d;
            frameGood_q <= frameGood_d;
            frameBad_q  <= frameBad_d;
            if (frameGood_d) begin
                frameByte_q <= shift_q;
            end
        end
    end

    // Next-state logic: bit collection on fe, inter-bit timeout between edges
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parOk_d     = parOk_q;
        timer_d     = timer_q;
        frameGood_d = 1'b0;
        frameBad_d  = 1'b0;

        if (state_q == IDLE) begin
            timer_d = '0;
        end else if (fe) begin
            timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
            timer_d    = '0;
            state_d    = IDLE;
            frameBad_d = 1'b1;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (fe) begin
            case (state_q)
                IDLE: begin
                    if (!datS) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {datS, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = PAR;
                    end
                end
                PAR: begin
                    parOk_d = ^{shift_q, datS};
                    state_d = STOP;
                end
                STOP: begin
                    frameGood_d = parOk_q & datS;
                    frameBad_d  = ~(parOk_q & datS);
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign push     = frameGood_q && (frameByte_q != 8'hE0) && (frameByte_q != 8'hF0);
    assign pushData = {ext_q, brk_q, frameByte_q};

    // Fold prefixes, update display and the saturating error counter
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            display_q <= '0;
            errCnt_q  <= '0;
        end else if (frameBad_q) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            display_q <= 16'hFFFF;
            if (errCnt_q != '1) begin
                errCnt_q <= errCnt_q + 1'b1;
            end
        end else if (frameGood_q) begin
            if (frameByte_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (frameByte_q == 8'hF0) begin
                brk_q <= 1'b1;
            end else begin
                display_q <= {brk_q ? 8'hF0 : (ext_q ? 8'hE0 : 8'h00), frameByte_q};
                ext_q     <= 1'b0;
                brk_q     <= 1'b0;
            end
        end
    end

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign pop       = evt_valid & evt_ready;
    assign wrEn      = push && (!fifoFull || pop);

    // FIFO pointers and the sticky overflow flag for dropped events
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (push && fifoFull && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are masked at the output while empty
    always_ff @(posedge CLOCK_50) begin
        if (wrEn) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushData;
        end
    end

    assign evt_valid = ~fifoEmpty;
    assign evt_data  = fifoEmpty ? 10'd0 : mem_q[rdPtr_q[AW-1:0]];
    assign display   = display_q;
    assign err_cnt   = errCnt_q;
    assign overflow  = overflow_q;

endmodule
